fpu16_divider: RTL

//  Iterative IEEE-754 binary16 divider computing a/b. It is the inverse operation of the FPU16 multiplier and sits beside it in the FPU datapath.

---
 rtl/fpu16_pkg.sv | 25 ++
 rtl/fpu16_classify.sv | 24 ++
 rtl/fpu16_divider.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fpu16_pkg.sv
// Shared FPU16 definitions: field widths, exponent bias, quiet NaN, flag bit positions
// and the divider FSM state encoding.
package fpu16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int ITER  = MAN_W + 2;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [14:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_DIVZERO   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fpu16_classify.sv
// Combinational binary16 operand classifier shared by the FPU16 multiplier and divider.
// Subnormals report as zero because the datapath flushes them.
module fpu16_classify
    import fpu16_pkg::*;
(
    input  logic [15:0] i_op,
    output logic        o_zero,
    output logic        o_inf,
    output logic        o_nan
);

    logic w_exp_zero;
    logic w_exp_max;
    logic w_man_nz;

    assign w_exp_zero = ~|i_op[MAN_W +: EXP_W];
    assign w_exp_max  = &i_op[MAN_W +: EXP_W];
    assign w_man_nz   = |i_op[MAN_W-1:0];

    assign o_zero = w_exp_zero;
    assign o_inf  = w_exp_max & ~w_man_nz;
    assign o_nan  = w_exp_max & w_man_nz;

endmodule

// File: rtl/fpu16_divider.sv
// Iterative binary16 divider: one restoring quotient bit per clock, truncating rounding,
// subnormals flushed to signed zero, valid/ready on both sides.
module fpu16_divider
    import fpu16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [3:0]  flags
);

    logic w_zero_a, w_inf_a, w_nan_a;
    logic w_zero_b, w_inf_b, w_nan_b;

    fpu16_classify u_class_a (.i_op(a), .o_zero(w_zero_a), .o_inf(w_inf_a), .o_nan(w_nan_a));
    fpu16_classify u_class_b (.i_op(b), .o_zero(w_zero_b), .o_inf(w_inf_b), .o_nan(w_nan_b));

    state_t             r_state;
    logic [3:0]         r_count;
    logic [MAN_W+1:0]   r_rem;
    logic [MAN_W:0]     r_div;
    logic [ITER-1:0]    r_q;
    logic signed [6:0]  r_exp;
    logic               r_sign;
    logic [15:0]        r_result;
    logic [3:0]         r_flags;

    logic               w_accept;
    logic               w_sign;
    logic               w_special;
    logic [15:0]        w_spec_result;
    logic [3:0]         w_spec_flags;
    logic signed [6:0]  w_exp_init;
    logic               w_ge;
    logic [MAN_W+1:0]   w_rem_sub;
    logic signed [6:0]  w_norm_exp;
    logic [MAN_W-1:0]   w_norm_man;
    logic [15:0]        w_norm_result;
    logic [3:0]         w_norm_flags;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign flags     = r_flags;

    assign w_accept   = in_valid & in_ready;
    assign w_sign     = a[15] ^ b[15];
    assign w_special  = w_zero_a | w_inf_a | w_nan_a | w_zero_b | w_inf_b | w_nan_b;
    assign w_exp_init = {2'b00, a[14:10]} - {2'b00, b[14:10]} + 7'(BIAS);

    // Special operands resolve in priority order; anything left over (0/x, x/inf) is signed zero.
    always_comb begin
        w_spec_result = {w_sign, 15'd0};
        w_spec_flags  = 4'd0;
        if (w_nan_a | w_nan_b | (w_zero_a & w_zero_b) | (w_inf_a & w_inf_b)) begin
            w_spec_result               = QNAN;
            w_spec_flags[FLAG_INVALID]  = 1'b1;
        end else if (w_inf_a) begin
            w_spec_result = {w_sign, INF_MAG};
        end else if (w_zero_b) begin
            w_spec_result               = {w_sign, INF_MAG};
            w_spec_flags[FLAG_DIVZERO]  = 1'b1;
        end
    end

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    // A quotient below 1.0 lands with its leading one at bit ITER-2, costing one exponent step.
    assign w_norm_exp = r_q[ITER-1] ? r_exp : (r_exp - 7'sd1);
    assign w_norm_man = r_q[ITER-1] ? r_q[ITER-2:1] : r_q[ITER-3:0];

    always_comb begin
        w_norm_result = {r_sign, w_norm_exp[4:0], w_norm_man};
        w_norm_flags  = 4'd0;
        if (w_norm_exp >= 7'sd31) begin
            w_norm_result               = {r_sign, INF_MAG};
            w_norm_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (w_norm_exp <= 7'sd0) begin
            w_norm_result                = {r_sign, 15'd0};
            w_norm_flags[FLAG_UNDERFLOW] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_count  <= 4'd0;
            r_rem    <= '0;
            r_div    <= '0;
            r_q      <= '0;
            r_exp    <= 7'sd0;
            r_sign   <= 1'b0;
            r_result <= 16'd0;
            r_flags  <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_sign;
                        if (w_special) begin
                            r_result <= w_spec_result;
                            r_flags  <= w_spec_flags;
                            r_state  <= DONE;
                        end else begin
                            r_rem   <= {2'b01, a[MAN_W-1:0]};
                            r_div   <= {1'b1, b[MAN_W-1:0]};
                            r_q     <= '0;
                            r_exp   <= w_exp_init;
                            r_count <= 4'd0;
                            r_state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    r_rem   <= {w_rem_sub[MAN_W:0], 1'b0};
                    r_q     <= {r_q[ITER-2:0], w_ge};
                    r_count <= r_count + 4'd1;
                    if (r_count == 4'(ITER - 1)) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_result <= w_norm_result;
                    r_flags  <= w_norm_flags;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
